// File: rtl/ps2_scan_ctrl_if.sv
// ps2_scan_ctrl_if: byte-in / key-event-out handshake between the PS/2 receiver, sequencer and consumer
interface ps2_scan_ctrl_if;
    logic [7:0] scan_byte;
    logic       scan_done;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       ev_valid;
    logic       ev_ready;
    modport master (output scan_byte, scan_done, ev_ready, input ev_code, ev_ext, ev_brk, ev_valid);
    modport slave (input scan_byte, scan_done, ev_ready, output ev_code, ev_ext, ev_brk, ev_valid);
endinterface

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: turns PS/2 set-2 bytes into queued key events with shift tracking
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ps2_scan_ctrl_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        shift_held,
    output logic                        proto_err,
    output logic                        overflow,
    input  logic                        clr_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
    state_t        state;
    logic [TW-1:0] tmo;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [9:0]    head;
    logic          shl, shr;
    logic          is_e0, is_f0, is_pre, is_stat, ext, brk, emit, full, pop, push;
    logic [9:0]    ent;
    logic [AW:0]   cnt_next;

    assign is_e0   = bus.scan_byte == 8'hE0;
    assign is_f0   = bus.scan_byte == 8'hF0;
    assign is_pre  = is_e0 || is_f0;
    assign is_stat = bus.scan_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    assign ext     = state == GOT_E0 || state == GOT_E0F0;
    assign brk     = state == GOT_F0 || state == GOT_E0F0;
    // Prefix bytes never emit; status bytes are only meaningful outside a prefix sequence
    assign emit    = bus.scan_done && !is_pre && !(state == IDLE && is_stat);
    assign ent     = {ext, brk, bus.scan_byte};
    assign full    = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign pop     = bus.ev_valid && bus.ev_ready;
    assign push    = emit && (!full || pop);
    assign cnt_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    assign bus.ev_valid = fifo_count != '0;
    assign {bus.ev_ext, bus.ev_brk, bus.ev_code} = head;
    assign shift_held = shl || shr;

    // Prefix parser with idle timeout that abandons a half-received sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo       <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            if (bus.scan_done) begin
                tmo <= '0;
                case (state)
                    IDLE:    state <= is_e0 ? GOT_E0 : is_f0 ? GOT_F0 : IDLE;
                    GOT_E0:  state <= is_f0 ? GOT_E0F0 : is_e0 ? GOT_E0 : IDLE;
                    default: begin
                        state     <= IDLE;
                        proto_err <= is_pre;
                    end
                endcase
            end else if (state == IDLE) begin
                tmo <= '0;
            end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                tmo       <= '0;
                proto_err <= 1'b1;
            end else begin
                tmo <= tmo + 1'b1;
            end
        end
    end

    // Shift state follows every non-extended event, queued or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shl <= 1'b0;
            shr <= 1'b0;
        end else if (emit && !ext) begin
            if (bus.scan_byte == 8'h12) shl <= !brk;
            if (bus.scan_byte == 8'h59) shr <= !brk;
        end
    end

    // Event storage; left unreset since only entries below fifo_count are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= ent;
    end

    // Pointers, count, sticky overflow and a registered head that holds once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr       <= '0;
            wptr       <= '0;
            fifo_count <= '0;
            head       <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            fifo_count <= cnt_next;
            if ((push || pop) && cnt_next != '0)
                head <= (fifo_count - (AW+1)'(pop) == '0) ? ent : mem[rptr + AW'(pop)];
            overflow <= (emit && !push) || (overflow && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: directed vector table, corner sequences and randomized run against an event-queue model
module tb_ps2_scan_ctrl;
    localparam int D = 4;
    localparam int T = 20;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [2:0] fifo_count;
    logic       shift_held, proto_err, overflow;
    int         checks = 0;
    int         errors = 0;

    ps2_scan_ctrl_if bus();

    ps2_scan_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fifo_count(fifo_count),
        .shift_held(shift_held), .proto_err(proto_err), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic [7:0] b;
        logic       r;
        logic       c;
        logic       v;
        logic [9:0] ev;
        logic [2:0] n;
        logic       sh;
        logic       er;
        logic       ov;
    } vec_t;
    vec_t tbl[$];

    logic [9:0] q[$];
    logic [9:0] last;
    bit         pe, pf, sl, sr, ov, err;
    int         w;

    function automatic void mreset();
        q.delete();
        last = '0;
        pe = 0; pf = 0; sl = 0; sr = 0; ov = 0; err = 0; w = 0;
    endfunction

    function automatic void model(logic d, logic [7:0] b, logic r, logic c);
        bit pop = q.size() != 0 && r;
        bit em = 0;
        bit drop = 0;
        logic [9:0] e = '0;
        err = 0;
        if (d) begin
            w = 0;
            if (b == 8'hE0 || b == 8'hF0) begin
                if (pf) begin
                    err = 1; pe = 0; pf = 0;
                end else if (b == 8'hE0) pe = 1;
                else pf = 1;
            end else if (!(!pe && !pf && b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
                em = 1; e = {pe, pf, b}; pe = 0; pf = 0;
            end
        end else if (pe || pf) begin
            if (w == T - 1) begin
                err = 1; pe = 0; pf = 0; w = 0;
            end else w++;
        end else w = 0;
        if (em && !e[9]) begin
            if (b == 8'h12) sl = !e[8];
            if (b == 8'h59) sr = !e[8];
        end
        if (em) drop = q.size() == D && !pop;
        if (pop) void'(q.pop_front());
        if (em && !drop) q.push_back(e);
        if (drop) ov = 1;
        else if (c) ov = 0;
        if (q.size() != 0) last = q[0];
    endfunction

    function automatic logic [16:0] act();
        return {bus.ev_valid, bus.ev_ext, bus.ev_brk, bus.ev_code, fifo_count, shift_held, proto_err, overflow};
    endfunction

    function automatic logic [16:0] mexp();
        return {q.size() != 0, last, 3'(q.size()), sl | sr, err, ov};
    endfunction

    task automatic chk(input string nm, input logic [16:0] a, input logic [16:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input logic d, input logic [7:0] b, input logic r, input logic c);
        bus.scan_done = d;
        bus.scan_byte = b;
        bus.ev_ready  = r;
        clr_ovf       = c;
        @(posedge clk);
        model(d, b, r, c);
        #1;
        chk("model", act(), mexp());
    endtask

    function automatic void add(logic d, logic [7:0] b, logic r, logic c, logic v, logic [9:0] ev,
                                logic [2:0] n, logic sh, logic er, logic o);
        tbl.push_back('{d, b, r, c, v, ev, n, sh, er, o});
    endfunction

    initial begin
        int seen;
        bit quiet;
        logic [7:0] rb;
        add(1, 8'h1C, 1, 0, 1, 10'h01C, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h01C, 0, 0, 0, 0);
        add(1, 8'hF0, 1, 0, 0, 10'h01C, 0, 0, 0, 0);
        add(1, 8'h1C, 1, 0, 1, 10'h11C, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h11C, 0, 0, 0, 0);
        add(1, 8'hE0, 1, 0, 0, 10'h11C, 0, 0, 0, 0);
        add(1, 8'h75, 1, 0, 1, 10'h275, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h275, 0, 0, 0, 0);
        add(1, 8'hE0, 1, 0, 0, 10'h275, 0, 0, 0, 0);
        add(1, 8'hF0, 1, 0, 0, 10'h275, 0, 0, 0, 0);
        add(1, 8'h75, 1, 0, 1, 10'h375, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h375, 0, 0, 0, 0);
        add(1, 8'hAA, 1, 0, 0, 10'h375, 0, 0, 0, 0);
        add(1, 8'hFA, 1, 0, 0, 10'h375, 0, 0, 0, 0);
        add(1, 8'h12, 1, 0, 1, 10'h012, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h012, 0, 1, 0, 0);
        add(1, 8'hE0, 1, 0, 0, 10'h012, 0, 1, 0, 0);
        add(1, 8'h12, 1, 0, 1, 10'h212, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h212, 0, 1, 0, 0);
        add(1, 8'hF0, 1, 0, 0, 10'h212, 0, 1, 0, 0);
        add(1, 8'h12, 1, 0, 1, 10'h112, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h112, 0, 0, 0, 0);
        add(1, 8'h59, 1, 0, 1, 10'h059, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h059, 0, 1, 0, 0);
        add(1, 8'h15, 0, 0, 1, 10'h015, 1, 1, 0, 0);
        add(1, 8'h1D, 0, 0, 1, 10'h015, 2, 1, 0, 0);
        add(1, 8'h24, 0, 0, 1, 10'h015, 3, 1, 0, 0);
        add(1, 8'h2D, 0, 0, 1, 10'h015, 4, 1, 0, 0);
        add(1, 8'h2C, 0, 0, 1, 10'h015, 4, 1, 0, 1);
        add(1, 8'h35, 0, 0, 1, 10'h015, 4, 1, 0, 1);
        add(0, 8'h00, 0, 1, 1, 10'h015, 4, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 10'h01D, 3, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 10'h024, 2, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 10'h02D, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h02D, 0, 1, 0, 0);
        add(1, 8'h1C, 0, 0, 1, 10'h01C, 1, 1, 0, 0);
        add(1, 8'h32, 0, 0, 1, 10'h01C, 2, 1, 0, 0);
        add(1, 8'h21, 0, 0, 1, 10'h01C, 3, 1, 0, 0);
        add(1, 8'h23, 0, 0, 1, 10'h01C, 4, 1, 0, 0);
        add(1, 8'h2B, 1, 0, 1, 10'h032, 4, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 10'h021, 3, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 10'h023, 2, 1, 0, 0);
        add(0, 8'h00, 1, 0, 1, 10'h02B, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h02B, 0, 1, 0, 0);
        add(1, 8'hF0, 1, 0, 0, 10'h02B, 0, 1, 0, 0);
        add(1, 8'hE0, 1, 0, 0, 10'h02B, 0, 1, 1, 0);
        add(0, 8'h00, 1, 0, 0, 10'h02B, 0, 1, 0, 0);
        add(1, 8'hE0, 1, 0, 0, 10'h02B, 0, 1, 0, 0);
        add(1, 8'hE0, 1, 0, 0, 10'h02B, 0, 1, 0, 0);
        add(1, 8'h74, 1, 0, 1, 10'h274, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 10'h274, 0, 1, 0, 0);

        bus.scan_done = 0;
        bus.scan_byte = 0;
        bus.ev_ready  = 0;
        mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset", act(), 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].b, tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d", i), act(), {tbl[i].v, tbl[i].ev, tbl[i].n, tbl[i].sh, tbl[i].er, tbl[i].ov});
        end

        seen = -1;
        step(1, 8'hF0, 1, 0);
        for (int k = 1; k <= T + 5; k++) begin
            step(0, 8'h00, 1, 0);
            if (proto_err && seen < 0) seen = k;
        end
        chk("timeout_cycle", 17'(seen), 17'(T));
        step(1, 8'h1C, 1, 0);
        chk("after_timeout", act(), {1'b1, 10'h01C, 3'd1, 1'b1, 1'b0, 1'b0});

        step(1, 8'hE0, 1, 0);
        step(1, 8'hF0, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        mreset();
        chk("async_reset", act(), 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h1C, 1, 0);
        chk("after_reset", act(), {1'b1, 10'h01C, 3'd1, 1'b0, 1'b0, 1'b0});

        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) quiet = !quiet;
            case ($urandom_range(0, 9))
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: rb = 8'h12;
                3: rb = 8'h59;
                4: rb = 8'hAA;
                5: rb = 8'h00;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            step(!quiet && $urandom_range(0, 1) == 1, rb, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Sequences the PS/2 byte receiver's output into key events.
- Consumes each received byte with its one-cycle done pulse.
- Parses the set-2 prefixes E0 (extended) and F0 (break), drops keyboard status bytes and tracks the shift keys.
- Queues decoded events in a small first-word-fall-through FIFO for the keyboard-to-ASCII/display logic downstream.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 100000, idle clk cycles after which a partial prefix sequence is abandoned (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock; same clock as the PS/2 receiver.
- rst_n  input  1  asynchronous active-low reset.
- scan_byte  input  8  received byte; valid only when scan_done=1.
- scan_done  input  1  one-cycle pulse: scan_byte is a new byte.
- ev_code  output  8  scan code of the event at the FIFO head.
- ev_ext  output  1  head event was E0-prefixed.
- ev_brk  output  1  head event is a release (F0-prefixed).
- ev_valid  output  1  FIFO not empty.
- ev_ready  input  1  consumer accepts the head event.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of entries held.
- shift_held  output  1  left (12) or right (59) shift currently pressed.
- proto_err  output  1  one-cycle pulse on prefix error or timeout.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, FIFO empty, timeout counter 0. All outputs 0: ev_code, ev_ext, ev_brk, ev_valid, fifo_count, shift_held, proto_err, overflow.
- A byte is processed only in a cycle with scan_done=1; scan_byte is ignored otherwise.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
- IDLE:
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - AA, FA, FE, EE, 00, FF → dropped, stay in IDLE, no error.
  - Any other byte → emit {ext=0, brk=0, code}.
- GOT_E0:
  - F0 → GOT_E0F0.
  - E0 → stay in GOT_E0.
  - Any other byte → emit {ext=1, brk=0, code}, go to IDLE.
- GOT_F0:
  - E0 or F0 → proto_err pulse, byte discarded, go to IDLE.
  - Any other byte → emit {ext=0, brk=1, code}, go to IDLE.
- GOT_E0F0:
  - E0 or F0 → proto_err pulse, byte discarded, go to IDLE.
  - Any other byte → emit {ext=1, brk=1, code}, go to IDLE.
- Timeout:
  - The counter clears on every scan_done and in IDLE; it increments each cycle in any other state.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, proto_err pulse, nothing emitted.
  - If scan_done arrives in the same cycle, the byte is processed normally and the timeout does not fire.
- Shift tracking:
  - Uses non-extended events only. A make of 12 sets the left bit, a break of 12 clears it; 59 works the same for the right bit.
  - shift_held is the OR of the two bits, registered, and updates the cycle after the emit.
  - Shift tracking updates even when the event is dropped on overflow.
- FIFO:
  - Entries are 10 bits {ext, brk, code}.
  - Push on emit; pop when ev_valid && ev_ready.
  - Output is first-word-fall-through: ev_code/ev_ext/ev_brk show the head entry whenever ev_valid=1, and hold their last value when empty.
  - Latency: scan_done in cycle N gives ev_valid=1 with the entry in cycle N+1 if the FIFO was empty.
  - Full with push and no pop: the new event is dropped, overflow is set, count is unchanged.
  - Full with push and pop in the same cycle: both proceed, count unchanged, no overflow.
  - Empty with ev_ready=1: no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- overflow: clr_ovf clears it; if clr_ovf and a new overflow occur in the same cycle, overflow stays set.
- Reset asserted mid-sequence (e.g. in GOT_E0F0): everything returns to reset values immediately; no partial event is emitted.

Test Plan:
- Send 1C, then F0 1C, with ev_ready=1 → events {1C, ext0, brk0} then {1C, ext0, brk1}; ev_valid high one cycle after each final scan_done; proto_err stays 0.
- Send E0 75, then E0 F0 75 → {75, ext1, brk0} then {75, ext1, brk1}. Send AA and FA from IDLE → no event, fifo_count stays 0.
- Send 12; check shift_held=1 one cycle after the emit. Send E0 12 → shift_held stays 1. Send F0 12 → shift_held=0. Send 59 → shift_held=1.
- Hold ev_ready=0 and send 6 make codes with FIFO_DEPTH=4 → fifo_count=4, overflow=1, head=first code. Pulse clr_ovf → overflow=0. Pop all four → codes come out in order, then ev_valid=0.
- With the FIFO full, push and pop in the same cycle → fifo_count stays 4, overflow stays 0, new code becomes the tail.
- Send F0 then nothing for TIMEOUT_CYCLES → proto_err pulse, FSM returns to IDLE, then 1C → {1C, ext0, brk0}. Separately, send F0 E0 → proto_err pulse and no event. Separately, assert rst_n=0 after E0 F0 → all outputs 0; next byte 1C → {1C, ext0, brk0}.
